// File: rtl/mfu_pkg.sv
// Shared types, widths and brick-mapping helpers for the m_fu fused multiplier.
package mfu_pkg;

  localparam int unsigned OP_W    = 8;
  localparam int unsigned RES_W   = 16;
  localparam int unsigned BRICK_W = 2;
  localparam int unsigned N_SLICE = OP_W / BRICK_W;

  typedef enum logic [1:0] {
    MODE_8B   = 2'd0,
    MODE_4B   = 2'd1,
    MODE_2B   = 2'd2,
    MODE_RSVD = 2'd3
  } mode_t;

  // A slice is signed iff it is the top slice of its current sub-word.
  function automatic logic slice_signed(mode_t m, int unsigned idx);
    case (m)
      MODE_8B: return (idx == N_SLICE - 1);
      MODE_4B: return (idx % 2 == 1);
      MODE_2B: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // A brick contributes only when both of its slices belong to the same sub-word pair.
  function automatic logic brick_active(mode_t m, int unsigned i, int unsigned j);
    case (m)
      MODE_8B: return 1'b1;
      MODE_4B: return (i / 2 == j / 2);
      MODE_2B: return (i == j);
      default: return 1'b0;
    endcase
  endfunction

  // Left shift of a brick product, by its position within its sub-word pair.
  function automatic int unsigned brick_shift(mode_t m, int unsigned i, int unsigned j);
    case (m)
      MODE_8B: return BRICK_W * (i + j);
      MODE_4B: return BRICK_W * ((i % 2) + (j % 2));
      default: return 0;
    endcase
  endfunction

endpackage

// File: rtl/mfu_bitbrick.sv
// 2x2-bit multiplier with per-operand signedness; produces a signed 6-bit product.
module mfu_bitbrick
  import mfu_pkg::*;
(
  input  logic [BRICK_W-1:0]          a,
  input  logic [BRICK_W-1:0]          b,
  input  logic                        sign_a,
  input  logic                        sign_b,
  output logic signed [2*BRICK_W+1:0] p
);

  logic signed [BRICK_W:0]     a_x, b_x;
  logic signed [2*BRICK_W+1:0] a_w, b_w;

  // Extend each operand to 3 bits (signed or unsigned), then multiply.
  always_comb begin
    a_x = {sign_a & a[BRICK_W-1], a};
    b_x = {sign_b & b[BRICK_W-1], b};
    a_w = (2*BRICK_W+2)'(a_x);
    b_w = (2*BRICK_W+2)'(b_x);
    p   = a_w * b_w;
  end

endmodule

// File: rtl/m_fu.sv
// Bit-Fusion style multi-precision multiplier: 8x8, 2x(4x4) or 4x(2x2) dot product.
// Optional macro MFU_INPUT_REG_EN adds an input register stage (latency 2 instead of 1).
module m_fu
  import mfu_pkg::*;
(
  input  logic                    clk,
  input  logic                    nrst,
  input  logic [OP_W-1:0]         a,
  input  logic [OP_W-1:0]         b,
  input  logic [1:0]              mode,
  output logic signed [RES_W-1:0] p
);

  logic [OP_W-1:0] a_op, b_op;
  mode_t           mode_op;

`ifdef MFU_INPUT_REG_EN
  logic [OP_W-1:0] a_q, b_q;
  mode_t           mode_q;

  // Input capture stage, cleared asynchronously.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      a_q    <= '0;
      b_q    <= '0;
      mode_q <= MODE_8B;
    end else begin
      a_q    <= a;
      b_q    <= b;
      mode_q <= mode_t'(mode);
    end
  end

  assign a_op    = a_q;
  assign b_op    = b_q;
  assign mode_op = mode_q;
`else
  assign a_op    = a;
  assign b_op    = b;
  assign mode_op = mode_t'(mode);
`endif

  logic [N_SLICE-1:0]          sgn;
  logic signed [2*BRICK_W+1:0] prod [N_SLICE*N_SLICE];
  logic signed [RES_W-1:0]     sum_d;
  logic signed [RES_W-1:0]     p_q;

  // Per-slice sign flags; a and b share the same packing, so one vector serves both.
  always_comb begin
    sgn = '0;
    for (int unsigned k = 0; k < N_SLICE; k++) begin
      sgn[k] = slice_signed(mode_op, k);
    end
  end

  for (genvar gi = 0; gi < N_SLICE; gi++) begin : g_a
    for (genvar gj = 0; gj < N_SLICE; gj++) begin : g_b
      mfu_bitbrick u_brick (
        .a      (a_op[BRICK_W*gi +: BRICK_W]),
        .b      (b_op[BRICK_W*gj +: BRICK_W]),
        .sign_a (sgn[gi]),
        .sign_b (sgn[gj]),
        .p      (prod[gi*N_SLICE + gj])
      );
    end
  end

  // Shift-add tree: sign-extend each active brick, shift by position, accumulate.
  always_comb begin
    logic signed [RES_W-1:0] ext;
    sum_d = '0;
    ext   = '0;
    for (int unsigned i = 0; i < N_SLICE; i++) begin
      for (int unsigned j = 0; j < N_SLICE; j++) begin
        ext = {{(RES_W-2*BRICK_W-2){prod[i*N_SLICE+j][2*BRICK_W+1]}}, prod[i*N_SLICE+j]};
        if (brick_active(mode_op, i, j)) begin
          sum_d = sum_d + (ext <<< brick_shift(mode_op, i, j));
        end
      end
    end
  end

  // Result register, cleared asynchronously.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) p_q <= '0;
    else       p_q <= sum_d;
  end

  assign p = p_q;

endmodule

// File: tb/tb_m_fu.sv
// Self-checking bench for m_fu: directed steps plus random vectors via a scoreboard queue.
module tb_m_fu;

`ifdef MFU_INPUT_REG_EN
  localparam int unsigned LAT = 2;
`else
  localparam int unsigned LAT = 1;
`endif

  logic               clk;
  logic               nrst;
  logic [7:0]         a, b;
  logic [1:0]         mode;
  logic signed [15:0] p;

  typedef struct {
    logic [15:0] exp;
    string       tag;
  } sb_t;

  sb_t sb [$];
  int  checks = 0;
  int  errors = 0;

  m_fu dut (
    .clk  (clk),
    .nrst (nrst),
    .a    (a),
    .b    (b),
    .mode (mode),
    .p    (p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] model(logic [7:0] ma, logic [7:0] mb, logic [1:0] mm);
    int r;
    logic [1:0] sa, sbb;
    r = 0;
    case (mm)
      2'd0: r = int'($signed(ma)) * int'($signed(mb));
      2'd1: r = int'($signed(ma[7:4])) * int'($signed(mb[7:4]))
              + int'($signed(ma[3:0])) * int'($signed(mb[3:0]));
      2'd2: for (int k = 0; k < 4; k++) begin
              sa  = ma[2*k +: 2];
              sbb = mb[2*k +: 2];
              r = r + int'($signed(sa)) * int'($signed(sbb));
            end
      default: r = 0;
    endcase
    return r[15:0];
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  // Drive one vector at the falling edge, then compare whatever has reached the output.
  task automatic step(input logic [7:0] sa, input logic [7:0] sbv, input logic [1:0] sm,
                      input logic [15:0] exp, input string tag);
    sb_t e;
    @(negedge clk);
    a    = sa;
    b    = sbv;
    mode = sm;
    sb.push_back('{exp: exp, tag: tag});
    @(posedge clk);
    #1;
    if (sb.size() >= LAT) begin
      e = sb.pop_front();
      check(e.tag, p, e.exp);
    end
  endtask

  initial begin
    logic [7:0] ra, rb;
    logic [1:0] rm;

    nrst = 1'b0;
    a    = 8'd5;
    b    = 8'd5;
    mode = 2'd0;

    // Held in reset with a live clock and nonzero inputs.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("reset_hold", p, 16'd0);
    end
    @(negedge clk);
    nrst = 1'b1;

    // Build up p = 25, then pull reset mid-cycle.
    for (int i = 0; i < int'(LAT); i++) step(8'd5, 8'd5, 2'd0, 16'd25, "pre_reset_25");
    check("pre_reset_p", p, 16'd25);
    #2;
    nrst = 1'b0;
    #1;
    check("async_reset", p, 16'd0);
    sb.delete();
    @(negedge clk);
    nrst = 1'b1;

    // mode 0 corners
    step(8'h80, 8'h80, 2'd0, 16'd16384,  "m0_min_min");
    step(8'h7F, 8'h80, 2'd0, -16'sd16256, "m0_max_min");
    step(8'd3,  8'hF9, 2'd0, -16'sd21,   "m0_3_m7");
    // mode 1
    step(8'h7F, 8'h21, 2'd1, 16'd13,  "m1_7f_21");
    step(8'h88, 8'h88, 2'd1, 16'd128, "m1_88_88");
    // mode 2
    step(8'hFF, 8'hFF, 2'd2, 16'd4,     "m2_ff_ff");
    step(8'hAA, 8'hAA, 2'd2, 16'd16,    "m2_aa_aa");
    step(8'h55, 8'hAA, 2'd2, -16'sd8,   "m2_55_aa");
    // mode 3
    step(8'h7F, 8'h7F, 2'd3, 16'd0, "m3_7f_7f");
    step(8'h80, 8'h80, 2'd3, 16'd0, "m3_80_80");
    // back-to-back mode switching on identical operands
    step(8'h7F, 8'h21, 2'd0, 16'd4191, "b2b_m0");
    step(8'h7F, 8'h21, 2'd1, 16'd13,   "b2b_m1");
    step(8'h7F, 8'h21, 2'd2, 16'd1,    "b2b_m2");

    // random vectors against the golden model
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rm = 2'($urandom_range(0, 2));
      step(ra, rb, rm, model(ra, rb, rm), "random");
    end

    // drain anything still in flight
    for (int i = 1; i < int'(LAT); i++) step(8'd0, 8'd0, 2'd3, 16'd0, "drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
